// File: rtl/sync_frame_receiver.sv
// Deframes HEADER,P0..P6,CHK byte streams into a validated 52-bit time/date sync word.
// Bad checksum, out-of-range fields and inter-byte timeouts are reported as error pulses.
module sync_frame_receiver #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [51:0] sync_buffer,
  output logic        sync,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StPayload, StChk, StEval} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [55:0]       payload_q, payload_d;
  logic [7:0]        xor_q, xor_d;
  logic              chk_ok_q, chk_ok_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [51:0]       sync_buffer_q, sync_buffer_d;
  logic              sync_q, sync_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              expired;
  logic              range_ok;

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return is_bcd(b) && (b >= lo) && (b <= hi);
  endfunction

  // BCD values compare correctly as plain hex, so bounds are written in BCD.
  assign range_ok = in_range(payload_q[7:0],   8'h00, 8'h99) &&
                    in_range(payload_q[15:8],  8'h01, 8'h12) &&
                    in_range(payload_q[23:16], 8'h01, 8'h31) &&
                    in_range(payload_q[31:24], 8'h00, 8'h23) &&
                    in_range(payload_q[39:32], 8'h00, 8'h59) &&
                    in_range(payload_q[47:40], 8'h00, 8'h59) &&
                    in_range(payload_q[55:48], 8'h00, 8'h06);

  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    payload_d     = payload_q;
    xor_d         = xor_q;
    chk_ok_d      = chk_ok_q;
    cnt_d         = cnt_q;
    sync_buffer_d = sync_buffer_q;
    sync_d        = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = StPayload;
          idx_d   = 3'd0;
          xor_d   = 8'h00;
          cnt_d   = '0;
        end
      end
      StPayload: begin
        if (rx_valid) begin
          payload_d[{idx_q, 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          cnt_d = '0;
          if (idx_q == 3'd6) state_d = StChk;
          else               idx_d   = idx_q + 3'd1;
        end else if (expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StChk: begin
        if (rx_valid) begin
          chk_ok_d = (rx_data == xor_q);
          cnt_d    = '0;
          state_d  = StEval;
        end else if (expired) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
          err_code_d  = 2'd3;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        // Any byte arriving here is dropped, including a HEADER.
        state_d = StIdle;
        if (!chk_ok_q) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd1;
        end else if (!range_ok) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'd2;
        end else begin
          sync_buffer_d = {payload_q[51:48], payload_q[47:0]};
          sync_d        = 1'b1;
          err_code_d    = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= 3'd0;
      payload_q     <= '0;
      xor_q         <= 8'h00;
      chk_ok_q      <= 1'b0;
      cnt_q         <= '0;
      sync_buffer_q <= '0;
      sync_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      payload_q     <= payload_d;
      xor_q         <= xor_d;
      chk_ok_q      <= chk_ok_d;
      cnt_q         <= cnt_d;
      sync_buffer_q <= sync_buffer_d;
      sync_q        <= sync_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign sync_buffer = sync_buffer_q;
  assign sync        = sync_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != StIdle);

endmodule
